disk_ii_controller: RTL and testbench
=====================================

Name: disk_ii_controller

Overview:
- Disk II interface card soft-switch controller; sits directly upstream of the two drive_ii instances on the A2FPGA multicard bus.
- Decodes the 16 slot I/O locations $C0n0–$C0nF and latches the stepper phases, motor, drive select, Q6 and Q7 state.
- Runs the ~1 s motor spin-down timer.
- Generates the per-drive active, read and write strobes consumed by drive_ii, and muxes drive data or write-protect status back onto the bus.

Parameters:
MOTOR_OFF_TICKS, 1_000_000, bus cycles the motor stays on after a motor-off access. Must be ≥1.
TIMER_WIDTH, 20, width of the spin-down counter. Must satisfy 2^TIMER_WIDTH > MOTOR_OFF_TICKS.

Ports:
clk_logic  in  1  system logic clock; only clock.
system_reset_n  in  1  synchronous active-low reset, sampled on clk_logic.
bus_cycle_end_i  in  1  one-clk_logic strobe at the end of each Apple II bus cycle (phi0 falling).
dev_sel_i  in  1  slot device select; held high for the whole phi0 window of a $C0nX access.
addr_i  in  4  bus address bits [3:0].
rw_n_i  in  1  bus read/write_n.
d1_data_i  in  8  data_o from drive 1 drive_ii.
d2_data_i  in  8  data_o from drive 2 drive_ii.
d1_wp_i  in  1  drive 1 write-protect; 1 = protected.
d2_wp_i  in  1  drive 2 write-protect; 1 = protected.
motor_phase_o  out  4  stepper phase latches [3:0], shared by both drives.
drive_sel_o  out  1  0 = drive 1, 1 = drive 2.
motor_on_o  out  1  spindle running, including the spin-down window.
d1_active_o  out  1  drive_active for drive 1.
d2_active_o  out  1  drive_active for drive 2.
write_mode_o  out  1  Q7 latch.
read_disk_o  out  1  read strobe to drive_ii.
write_reg_o  out  1  write-register load to drive_ii.
rd_data_o  out  8  data returned to the bus.
rd_data_en_o  out  1  this block drives the bus.

Behaviour:
- Latch update rule: all latches update only on a cycle where bus_cycle_end_i & dev_sel_i are both high. One update per bus access, regardless of how long dev_sel_i is held.
- Address map, addr_i:
  - 0–7: phase[addr[2:1]] <= addr[0].
  - 8: motor-off request.
  - 9: motor-on.
  - A: drive_sel <= 0.
  - B: drive_sel <= 1.
  - C/D: Q6 <= addr[0].
  - E/F: Q7 <= addr[0].
  - Reads and writes act identically.
- Motor control state machine, states OFF / ON / SPINDOWN:
  - OFF + access 9 -> ON.
  - ON + access 8 -> SPINDOWN, with timer loaded to MOTOR_OFF_TICKS-1.
  - SPINDOWN: timer decrements on each bus_cycle_end_i. When it reaches 0 on a bus_cycle_end_i -> OFF.
  - SPINDOWN + access 9 -> ON, timer cleared. If this coincides with expiry, ON wins.
  - Access 8 in SPINDOWN does not reload the timer.
  - Access 8 in OFF: no effect.
- Output decodes:
  - motor_on_o = (state != OFF).
  - d1_active_o = motor_on_o & ~drive_sel_o; d2_active_o = motor_on_o & drive_sel_o.
  - A drive-select change during ON or SPINDOWN moves activity to the other drive on the next clock; the timer is unaffected.
- Effective switch values (combinational, so the current access sees its own effect):
  - eff_q6 = addr_i in {C,D} ? addr_i[0] : Q6.
  - eff_q7 = addr_i in {E,F} ? addr_i[0] : Q7.
- Strobes (combinational, level for the whole dev_sel_i window):
  - read_disk_o = dev_sel_i & (addr_i == C).
  - write_reg_o = dev_sel_i & ~rw_n_i & eff_q6 & eff_q7 & addr_i[0].
- Bus read data:
  - rd_data_en_o = dev_sel_i & rw_n_i & ~addr_i[0].
  - rd_data_o = {eff_q6, eff_q7}: 00 -> selected drive data; 10 -> {selected wp, 7'b0}; otherwise selected drive data.
  - rd_data_o = 8'h00 when rd_data_en_o = 0.
- Reset (synchronous, system_reset_n low on a clk_logic edge) forces:
  - phases 0, drive_sel 0, Q6 0, Q7 0, state OFF, timer 0.
  - All outputs 0, including in SPINDOWN mid-count.
- Outputs motor_phase_o, drive_sel_o, write_mode_o and the active outputs are registered: they change one clk_logic after the qualifying strobe.

Test Plan:
- Reset sequencing: reset held low 2 clocks mid-SPINDOWN -> all outputs 0, state OFF; first access after release behaves as from OFF.
- Phase stepping: accesses $C0n1, $C0n3, $C0n0 -> motor_phase_o steps 0001, 0011, 0010; dev_sel_i held 20 clocks with one bus_cycle_end_i -> exactly one update.
- Motor spin-down: MOTOR_OFF_TICKS=5; access 9 then 8 -> d1_active_o stays 1 for exactly 5 further bus_cycle_end_i, then 0. Access 9 on the 5th (expiry) cycle -> stays 1.
- Drive select: motor on, access B -> d1_active_o 0 and d2_active_o 1 on the next clock. Access 8 -> d2 spins down only.
- Write-protect sense and data read: d2_wp_i=1, drive 2 selected; read $C0nD, then read $C0nE -> rd_data_o 8'h80, rd_data_en_o 1. Read $C0nC with d2_data_i=8'hD5 -> rd_data_o 8'hD5, read_disk_o 1. Odd read -> rd_data_en_o 0.
- Write-register load: Q6=1 via $C0nD; write $C0nF -> write_reg_o 1 during that access, write_mode_o 1 afterwards. Write $C0nE -> write_mode_o 0.

Source files
------------

// File: rtl/disk_ii_controller_if.sv
// Slot bus and drive-side signals of the Disk II controller card.
// master = bus/drive side, slave = controller.
interface disk_ii_controller_if;
  logic       bus_cycle_end_i;
  logic       dev_sel_i;
  logic [3:0] addr_i;
  logic       rw_n_i;
  logic [7:0] d1_data_i;
  logic [7:0] d2_data_i;
  logic       d1_wp_i;
  logic       d2_wp_i;
  logic [3:0] motor_phase_o;
  logic       drive_sel_o;
  logic       motor_on_o;
  logic       d1_active_o;
  logic       d2_active_o;
  logic       write_mode_o;
  logic       read_disk_o;
  logic       write_reg_o;
  logic [7:0] rd_data_o;
  logic       rd_data_en_o;

  modport master (
    output bus_cycle_end_i, dev_sel_i, addr_i, rw_n_i,
           d1_data_i, d2_data_i, d1_wp_i, d2_wp_i,
    input  motor_phase_o, drive_sel_o, motor_on_o, d1_active_o, d2_active_o,
           write_mode_o, read_disk_o, write_reg_o, rd_data_o, rd_data_en_o
  );

  modport slave (
    input  bus_cycle_end_i, dev_sel_i, addr_i, rw_n_i,
           d1_data_i, d2_data_i, d1_wp_i, d2_wp_i,
    output motor_phase_o, drive_sel_o, motor_on_o, d1_active_o, d2_active_o,
           write_mode_o, read_disk_o, write_reg_o, rd_data_o, rd_data_en_o
  );
endinterface

// File: rtl/disk_ii_controller.sv
// Disk II soft-switch controller: $C0nX latches, motor spin-down timer,
// drive_ii strobes and bus read-data mux.
module disk_ii_controller #(
  parameter int MOTOR_OFF_TICKS = 1_000_000,
  parameter int TIMER_WIDTH     = 20
) (
  input  logic               clk_logic,
  input  logic               system_reset_n,
  disk_ii_controller_if.slave bus
);
  typedef enum logic [1:0] {MOTOR_OFF, MOTOR_ON, MOTOR_SPINDOWN} motor_state_t;

  motor_state_t           state;
  logic [TIMER_WIDTH-1:0] timer;
  logic [3:0]             phase;
  logic                   drive_sel, q6, q7;
  logic                   access, acc_on, acc_off;
  logic                   eff_q6, eff_q7, rd_en;
  logic [7:0]             sel_data;
  logic                   sel_wp;

  // dev_sel may span many clocks; only the end-of-cycle strobe commits.
  assign access  = bus.bus_cycle_end_i & bus.dev_sel_i;
  assign acc_on  = access & (bus.addr_i == 4'h9);
  assign acc_off = access & (bus.addr_i == 4'h8);

  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      phase     <= '0;
      drive_sel <= 1'b0;
      q6        <= 1'b0;
      q7        <= 1'b0;
      state     <= MOTOR_OFF;
      timer     <= '0;
    end else begin
      if (access) begin
        if (!bus.addr_i[3]) phase[bus.addr_i[2:1]] <= bus.addr_i[0];
        else begin
          case (bus.addr_i[2:1])
            2'b01:   drive_sel <= bus.addr_i[0];
            2'b10:   q6        <= bus.addr_i[0];
            2'b11:   q7        <= bus.addr_i[0];
            default: ;
          endcase
        end
      end
      case (state)
        MOTOR_OFF: if (acc_on) state <= MOTOR_ON;
        MOTOR_ON: if (acc_off) begin
          state <= MOTOR_SPINDOWN;
          timer <= TIMER_WIDTH'(MOTOR_OFF_TICKS - 1);
        end
        MOTOR_SPINDOWN: begin
          // A motor-on access beats a simultaneous expiry.
          if (acc_on) begin
            state <= MOTOR_ON;
            timer <= '0;
          end else if (bus.bus_cycle_end_i) begin
            if (timer == '0) state <= MOTOR_OFF;
            else timer <= timer - 1'b1;
          end
        end
        default: state <= MOTOR_OFF;
      endcase
    end
  end

  assign bus.motor_phase_o = phase;
  assign bus.drive_sel_o   = drive_sel;
  assign bus.write_mode_o  = q7;
  assign bus.motor_on_o    = (state != MOTOR_OFF);
  assign bus.d1_active_o   = (state != MOTOR_OFF) & ~drive_sel;
  assign bus.d2_active_o   = (state != MOTOR_OFF) & drive_sel;

  // The current access already sees its own Q6/Q7 effect.
  assign eff_q6   = (bus.addr_i[3:1] == 3'b110) ? bus.addr_i[0] : q6;
  assign eff_q7   = (bus.addr_i[3:1] == 3'b111) ? bus.addr_i[0] : q7;
  assign sel_data = drive_sel ? bus.d2_data_i : bus.d1_data_i;
  assign sel_wp   = drive_sel ? bus.d2_wp_i : bus.d1_wp_i;
  assign rd_en    = system_reset_n & bus.dev_sel_i & bus.rw_n_i & ~bus.addr_i[0];

  assign bus.read_disk_o  = system_reset_n & bus.dev_sel_i & (bus.addr_i == 4'hC);
  assign bus.write_reg_o  = system_reset_n & bus.dev_sel_i & ~bus.rw_n_i
                            & eff_q6 & eff_q7 & bus.addr_i[0];
  assign bus.rd_data_en_o = rd_en;
  assign bus.rd_data_o    = !rd_en ? 8'h00 :
                            (eff_q6 & ~eff_q7) ? {sel_wp, 7'b0} : sel_data;
endmodule

// File: tb/tb_disk_ii_controller.sv
// Self-checking bench for disk_ii_controller: directed scenarios plus a
// randomized run against a countdown-based reference model.
module tb_disk_ii_controller;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  disk_ii_controller_if bus();

  disk_ii_controller #(.MOTOR_OFF_TICKS(N), .TIMER_WIDTH(4)) dut (
    .clk_logic(clk), .system_reset_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: motor is on/off plus "bus cycles left before stop".
  bit [3:0] m_phase;
  bit       m_sel, m_q6, m_q7, m_on, m_spin;
  int       m_rem;

  function automatic void model_reset();
    m_phase = '0; m_sel = 0; m_q6 = 0; m_q7 = 0; m_on = 0; m_spin = 0; m_rem = 0;
  endfunction

  function automatic void model_end(input bit acc, input logic [3:0] a);
    if (m_spin) begin
      m_rem--;
      if (m_rem == 0) begin m_on = 0; m_spin = 0; end
    end
    if (acc) begin
      if (a < 8) m_phase[a[2:1]] = a[0];
      else case (a)
        4'h8: if (m_on && !m_spin) begin m_spin = 1; m_rem = N; end
        4'h9: begin m_on = 1; m_spin = 0; end
        4'hA, 4'hB: m_sel = a[0];
        4'hC, 4'hD: m_q6 = a[0];
        default: m_q7 = a[0];
      endcase
    end
  endfunction

  function automatic logic [8:0] exp_regs();
    return {m_phase, m_sel, m_on, m_on && !m_sel, m_on && m_sel, m_q7};
  endfunction

  function automatic logic [8:0] got_regs();
    return {bus.motor_phase_o, bus.drive_sel_o, bus.motor_on_o,
            bus.d1_active_o, bus.d2_active_o, bus.write_mode_o};
  endfunction

  // {read_disk, write_reg, rd_data_en, rd_data} for the stimulus now on the bus
  function automatic logic [10:0] exp_comb();
    bit q6 = (bus.addr_i == 4'hC || bus.addr_i == 4'hD) ? bus.addr_i[0] : m_q6;
    bit q7 = (bus.addr_i == 4'hE || bus.addr_i == 4'hF) ? bus.addr_i[0] : m_q7;
    bit rd = bus.dev_sel_i && bus.rw_n_i && !bus.addr_i[0];
    logic [7:0] d;
    if (!rd) d = 8'h00;
    else if (q6 && !q7) d = {(m_sel ? bus.d2_wp_i : bus.d1_wp_i), 7'b0};
    else d = m_sel ? bus.d2_data_i : bus.d1_data_i;
    return {bus.dev_sel_i && bus.addr_i == 4'hC,
            bus.dev_sel_i && !bus.rw_n_i && q6 && q7 && bus.addr_i[0], rd, d};
  endfunction

  function automatic logic [10:0] got_comb();
    return {bus.read_disk_o, bus.write_reg_o, bus.rd_data_en_o, bus.rd_data_o};
  endfunction

  task automatic start_access(input logic [3:0] a, input logic rw);
    @(negedge clk);
    bus.dev_sel_i = 1'b1; bus.addr_i = a; bus.rw_n_i = rw;
    #1;
  endtask

  task automatic end_access(input int hold);
    repeat (hold - 1) @(negedge clk);
    bus.bus_cycle_end_i = 1'b1;
    @(negedge clk);
    bus.bus_cycle_end_i = 1'b0; bus.dev_sel_i = 1'b0;
    model_end(1'b1, bus.addr_i);
    #1;
  endtask

  task automatic access(input logic [3:0] a, input logic rw);
    start_access(a, rw);
    end_access(1);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.bus_cycle_end_i = 1'b1;
    @(negedge clk);
    bus.bus_cycle_end_i = 1'b0;
    model_end(1'b0, 4'h0);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1; model_reset(); #1;
    checks++;
    if (got_regs() !== 9'h0) begin failures++; $display("FAIL reset_regs got=%h exp=%h", got_regs(), 9'h0); end
    // Reset held 2 clocks mid-spindown with an access in flight
    access(4'h9, 1); access(4'h8, 1); idle_cycle();
    start_access(4'hC, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({got_regs(), got_comb()} !== 20'h0) begin
      failures++; $display("FAIL reset_midspin got=%h exp=%h", {got_regs(), got_comb()}, 20'h0);
    end
    bus.dev_sel_i = 1'b0; rst_n = 1'b1; model_reset();
    access(4'h8, 1);
    checks++;
    if (bus.motor_on_o !== 1'b0) begin failures++; $display("FAIL reset_off8 got=%b exp=0", bus.motor_on_o); end
    access(4'h9, 1);
    checks++;
    if (bus.d1_active_o !== 1'b1) begin failures++; $display("FAIL reset_on9 got=%b exp=1", bus.d1_active_o); end
  endtask

  task automatic test_phase();
    logic [3:0] seq [3] = '{4'h1, 4'h3, 4'h0};
    logic [3:0] exp [3] = '{4'b0001, 4'b0011, 4'b0010};
    for (int i = 0; i < 3; i++) begin
      start_access(seq[i], 1);
      end_access(i == 0 ? 20 : 1);
      checks++;
      if (bus.motor_phase_o !== exp[i]) begin
        failures++; $display("FAIL phase_%0d got=%b exp=%b", i, bus.motor_phase_o, exp[i]);
      end
    end
  endtask

  task automatic test_spindown();
    access(4'hA, 1); access(4'h9, 1); access(4'h8, 1);
    for (int k = 1; k <= N; k++) begin
      idle_cycle();
      checks++;
      if (bus.d1_active_o !== (k < N) || got_regs() !== exp_regs()) begin
        failures++; $display("FAIL spindown_%0d got=%b exp=%b", k, bus.d1_active_o, k < N);
      end
    end
    access(4'h9, 1); access(4'h8, 1);
    repeat (N - 1) idle_cycle();
    access(4'h9, 1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.d1_active_o !== 1'b1) begin failures++; $display("FAIL expiry_on_%0d got=%b exp=1", k, bus.d1_active_o); end
      idle_cycle();
    end
    access(4'h8, 1);
    repeat (N) idle_cycle();
    checks++;
    if (bus.motor_on_o !== 1'b0) begin failures++; $display("FAIL spindown_off got=%b exp=0", bus.motor_on_o); end
  endtask

  task automatic test_drive_sel();
    access(4'h9, 1);
    start_access(4'hB, 1);
    checks++;
    if ({bus.d1_active_o, bus.d2_active_o} !== 2'b10) begin
      failures++; $display("FAIL dsel_before got=%b exp=10", {bus.d1_active_o, bus.d2_active_o});
    end
    end_access(1);
    checks++;
    if ({bus.d1_active_o, bus.d2_active_o} !== 2'b01) begin
      failures++; $display("FAIL dsel_after got=%b exp=01", {bus.d1_active_o, bus.d2_active_o});
    end
    access(4'h8, 1);
    for (int k = 1; k <= N; k++) begin
      idle_cycle();
      checks++;
      if ({bus.d1_active_o, bus.d2_active_o} !== {1'b0, k < N}) begin
        failures++; $display("FAIL dsel_spin_%0d got=%b exp=%b", k, {bus.d1_active_o, bus.d2_active_o}, {1'b0, k < N});
      end
    end
  endtask

  task automatic test_read_data();
    bus.d2_wp_i = 1'b1; bus.d1_wp_i = 1'b0; bus.d2_data_i = 8'hD5; bus.d1_data_i = 8'h3C;
    access(4'hB, 1);
    start_access(4'hD, 1);
    checks++;
    if ({bus.rd_data_en_o, bus.rd_data_o} !== 9'h000) begin
      failures++; $display("FAIL rd_odd got=%h exp=%h", {bus.rd_data_en_o, bus.rd_data_o}, 9'h000);
    end
    end_access(1);
    start_access(4'hE, 1);
    checks++;
    if ({bus.rd_data_en_o, bus.rd_data_o} !== 9'h180) begin
      failures++; $display("FAIL rd_wp got=%h exp=%h", {bus.rd_data_en_o, bus.rd_data_o}, 9'h180);
    end
    end_access(1);
    start_access(4'hC, 1);
    checks++;
    if ({bus.read_disk_o, bus.rd_data_en_o, bus.rd_data_o} !== 10'h3D5) begin
      failures++; $display("FAIL rd_data got=%h exp=%h", {bus.read_disk_o, bus.rd_data_en_o, bus.rd_data_o}, 10'h3D5);
    end
    end_access(1);
  endtask

  task automatic test_write_reg();
    access(4'hD, 1);
    start_access(4'hF, 0);
    checks++;
    if (bus.write_reg_o !== 1'b1) begin failures++; $display("FAIL wreg_f got=%b exp=1", bus.write_reg_o); end
    end_access(1);
    checks++;
    if (bus.write_mode_o !== 1'b1) begin failures++; $display("FAIL wmode_set got=%b exp=1", bus.write_mode_o); end
    start_access(4'hE, 0);
    checks++;
    if (bus.write_reg_o !== 1'b0) begin failures++; $display("FAIL wreg_e got=%b exp=0", bus.write_reg_o); end
    end_access(1);
    checks++;
    if (bus.write_mode_o !== 1'b0) begin failures++; $display("FAIL wmode_clr got=%b exp=0", bus.write_mode_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) idle_cycle();
      else begin
        bus.d1_data_i = 8'($urandom); bus.d2_data_i = 8'($urandom);
        bus.d1_wp_i = 1'($urandom); bus.d2_wp_i = 1'($urandom);
        start_access(4'($urandom), 1'($urandom));
        checks++;
        if (got_comb() !== exp_comb()) begin
          failures++; $display("FAIL rand_comb_%0d addr=%h got=%h exp=%h", i, bus.addr_i, got_comb(), exp_comb());
        end
        end_access(int'($urandom_range(4, 1)));
      end
      checks++;
      if (got_regs() !== exp_regs()) begin
        failures++; $display("FAIL rand_regs_%0d got=%h exp=%h", i, got_regs(), exp_regs());
      end
    end
  endtask

  initial begin
    bus.bus_cycle_end_i = 1'b0; bus.dev_sel_i = 1'b0; bus.addr_i = 4'h0; bus.rw_n_i = 1'b1;
    bus.d1_data_i = 8'h00; bus.d2_data_i = 8'h00; bus.d1_wp_i = 1'b0; bus.d2_wp_i = 1'b0;
    model_reset();
    test_reset();
    test_phase();
    test_spindown();
    test_drive_sel();
    test_read_data();
    test_write_reg();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
